fi_campaign_ctrl: RTL and testbench
===================================

# fi_campaign_ctrl

Sequencer that runs an automated stuck-at fault-injection campaign on the non-TMR `traditional_systolic` array. It owns the array's operand, control, reset and `fault_inject_bus` inputs for the duration of a campaign. It first runs one fault-free sanity pass, then injects stuck-at-0 and stuck-at-1 into each PE in turn. For every run it compares the DUT `bottom_out_bus` against a fault-free golden array and records whether the fault was detected.

## Interface
- `ROWS`, default 2: array rows.
- `COLS`, default 2: array columns.
- `WORD_SIZE`, default 16: operand/result width.
- `LAT`, default `ROWS+COLS`: cycles from operand drive to first valid bottom output.
- `SAMPLES`, default `ROWS*COLS`: compare cycles per run.

Ports (N = `ROWS*COLS`):
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `start` in 1: begin campaign; honoured only in IDLE.
- `abort` in 1: terminate campaign.
- `op_left` in `ROWS*WORD_SIZE`: left operand pattern.
- `op_top` in `COLS*WORD_SIZE`: top operand pattern.
- `arr_rst` out 1: active-high reset to both arrays.
- `ctl_stat_bit_in` out 1: array control; constant 0 during runs.
- `ctl_dummy_fsm_op2_select_in` out 1: constant 1 during runs.
- `ctl_dummy_fsm_out_select_in` out 1: constant 1 during runs.
- `left_in_bus` out `ROWS*WORD_SIZE`: operands to both arrays.
- `top_in_bus` out `COLS*WORD_SIZE`: operands to both arrays.
- `fault_inject_bus` out `2*N`: DUT injection field.
  - Slot p = `col*ROWS+row`, bits `[2p+1:2p]` = {stuck_at_1, enable}.
- `dut_bottom_out_bus` in `COLS*WORD_SIZE`: DUT result.
- `gold_bottom_out_bus` in `COLS*WORD_SIZE`: golden array result.
- `busy` out 1: campaign in progress.
- `done` out 1: one-cycle pulse at campaign end.
- `sanity_fail` out 1: sticky; fault-free run mismatched.
- `res_valid` out 1: one-cycle pulse per faulted run.
- `res_pe` out `$clog2(N)`: PE index p of the reported run.
- `res_stuck` out 1: stuck value of the reported run.
- `res_detected` out 1: reported run saw a mismatch.
- `detect_map` out `2*N`: sticky; bit `2p+s` set when stuck-at-s in PE p was detected.

## Operation
- States: IDLE, ARST, RUN, SAMPLE, REPORT, DONE.
- IDLE:
  - `busy`=0, `arr_rst`=0, buses and control outputs 0.
  - `start`=1 moves to ARST with run index k=0, and clears `detect_map` and `sanity_fail`.
- Run order:
  - k=0: fault-free, `fault_inject_bus`=0.
  - k=1..2N: p=(k-1)>>1, s=(k-1)&1.
  - `fault_inject_bus` has slot p = {s,1}; all other bits 0.
- ARST (2 cycles):
  - `arr_rst`=1 and operand buses 0.
  - `fault_inject_bus` carries run k's pattern from ARST entry through REPORT.
- RUN (`LAT` cycles): `arr_rst`=0, operand buses = `op_left`/`op_top`, control bits = 0/1/1. Operands and control bits hold at these values through SAMPLE.
- SAMPLE (`SAMPLES` cycles): each cycle, `mismatch |= (dut_bottom_out_bus != gold_bottom_out_bus)`. `mismatch` is cleared on ARST entry.
- REPORT (1 cycle):
  - k=0: `sanity_fail`=`mismatch`. On mismatch, go to DONE (campaign ends); otherwise k=1 and go to ARST.
  - k>0: `res_valid`=1 with `res_pe`=p, `res_stuck`=s, `res_detected`=`mismatch`. `detect_map[2p+s]` is set if `mismatch`. If k=2N go to DONE, else k+1 and go to ARST.
- DONE (1 cycle): `done`=1, all buses 0, then go to IDLE.
- `abort`=1 in any non-IDLE state goes to DONE next cycle. It clears `fault_inject_bus` and operands immediately (registered, next cycle), emits no `res_valid` for the partial run, and leaves `detect_map` holding prior results.
- `abort` has priority over a simultaneous REPORT transition; that run's result is discarded.
- `start` in a non-IDLE state is ignored. `start` and `abort` together in IDLE: `start` wins.

## Timing
- All outputs are registered.
- Reset values: every output 0, state IDLE, k=0. `rst` low mid-campaign zeroes `fault_inject_bus` and all outputs asynchronously.
- Run length = 2+`LAT`+`SAMPLES`+1 cycles; campaign = (2N+1) runs.
- With `start` sampled at edge E:
  - `busy` rises after E.
  - ARST of run 0 occupies cycles E+1, E+2.
  - `done` is high in cycle E+1+(2N+1)(3+`LAT`+`SAMPLES`).
- `busy` falls in the cycle after `done`.
- Comparison uses the value present at each SAMPLE-cycle rising edge; inputs need no registering.

## Test plan
Defaults apply (2x2, 16-bit, `LAT`=4, `SAMPLES`=4), giving 11 cycles per run and 9 runs. `op_left`={5,4}, `op_top`={3,2}.
- Reset: drive `rst`=0 with random inputs -> all outputs 0 and `busy`=0; after release, idle with no activity until `start`.
- Full campaign: stub DUT = gold XOR 1 whenever `fault_inject_bus`≠0, except slot 2 stuck-0. Pulse `start` at E -> 8 `res_valid` pulses in order p0s0,p0s1,…,p3s1; `detect_map`=8'b11101111; `done` in cycle E+100; `sanity_fail`=0.
- Sanity failure: force dut≠gold during run 0 SAMPLE -> `sanity_fail`=1, zero `res_valid` pulses, `done` in cycle E+12, `detect_map`=0.
- Injection encoding: during run k=6 (p=2, s=1), `fault_inject_bus`=8'b00110000; `arr_rst`=1 exactly in that run's first 2 cycles.
- Abort mid-run: assert `abort` in SAMPLE of run k=3 -> no `res_valid` for k=3, `done` the next cycle, `fault_inject_bus`=0, `detect_map` keeps the bits for k=1,2.
- `start` while busy: pulse `start` at E+30 -> ignored; campaign order and `done` cycle are unchanged. Reset asserted at E+50 -> outputs 0 immediately, then IDLE.

Source files
------------

// File: rtl/fi_campaign_ctrl.sv
// Stuck-at fault-injection campaign sequencer for the non-TMR systolic array.
// Runs one fault-free sanity pass, then stuck-at-0/1 on every PE, comparing DUT vs golden outputs.
module fi_campaign_ctrl #(
    parameter int ROWS      = 2,
    parameter int COLS      = 2,
    parameter int WORD_SIZE = 16,
    parameter int LAT       = ROWS + COLS,
    parameter int SAMPLES   = ROWS * COLS,
    localparam int N        = ROWS * COLS,
    localparam int PW       = (N > 1) ? $clog2(N) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      abort,
    input  logic [ROWS*WORD_SIZE-1:0] op_left,
    input  logic [COLS*WORD_SIZE-1:0] op_top,
    output logic                      arr_rst,
    output logic                      ctl_stat_bit_in,
    output logic                      ctl_dummy_fsm_op2_select_in,
    output logic                      ctl_dummy_fsm_out_select_in,
    output logic [ROWS*WORD_SIZE-1:0] left_in_bus,
    output logic [COLS*WORD_SIZE-1:0] top_in_bus,
    output logic [2*N-1:0]            fault_inject_bus,
    input  logic [COLS*WORD_SIZE-1:0] dut_bottom_out_bus,
    input  logic [COLS*WORD_SIZE-1:0] gold_bottom_out_bus,
    output logic                      busy,
    output logic                      done,
    output logic                      sanity_fail,
    output logic                      res_valid,
    output logic [PW-1:0]             res_pe,
    output logic                      res_stuck,
    output logic                      res_detected,
    output logic [2*N-1:0]            detect_map,
    output logic [2:0]                dbg_state
);
    localparam int FW   = 2 * N;
    localparam int KW   = $clog2(2 * N + 1);
    localparam int CMAX = (LAT > SAMPLES) ? LAT : SAMPLES;
    localparam int CW   = $clog2(CMAX + 2);
    localparam logic [KW-1:0] K_LAST = KW'(2 * N);

    typedef enum logic [2:0] {S_IDLE, S_ARST, S_RUN, S_SAMPLE, S_REPORT, S_DONE} state_e;

    state_e                    state_q, state_d;
    logic [CW-1:0]             cnt_q, cnt_d;
    logic [KW-1:0]             k_q, k_d;
    logic                      mismatch_q, mismatch_d;
    logic                      arr_rst_q, arr_rst_d;
    logic                      ctl_op2_q, ctl_op2_d;
    logic                      ctl_out_q, ctl_out_d;
    logic [ROWS*WORD_SIZE-1:0] left_q, left_d;
    logic [COLS*WORD_SIZE-1:0] top_q, top_d;
    logic [FW-1:0]             fault_q, fault_d;
    logic                      busy_q, busy_d;
    logic                      done_q, done_d;
    logic                      sanity_q, sanity_d;
    logic                      res_valid_q, res_valid_d;
    logic [PW-1:0]             res_pe_q, res_pe_d;
    logic                      res_stuck_q, res_stuck_d;
    logic                      res_det_q, res_det_d;
    logic [FW-1:0]             dmap_q, dmap_d;
    logic                      mismatch_fin;
    logic                      report_now;
    logic [KW-1:0]             km1;

    // Run k>0 targets PE (k-1)>>1 with stuck value (k-1)&1; slot bits are {stuck, enable}.
    function automatic logic [FW-1:0] fault_pattern(input logic [KW-1:0] k);
        logic [KW-1:0] idx;
        logic [KW-1:0] base;
        idx  = k - KW'(1);
        base = {idx[KW-1:1], 1'b0};
        if (k == '0) return '0;
        return (FW'(1) | (FW'(idx[0]) << 1)) << base;
    endfunction

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        k_d          = k_q;
        mismatch_d   = mismatch_q;
        mismatch_fin = mismatch_q | (dut_bottom_out_bus != gold_bottom_out_bus);
        km1          = k_q - KW'(1);

        case (state_q)
            S_IDLE:   if (start) begin
                          state_d = S_ARST;
                          k_d     = '0;
                      end
            S_ARST:   if (cnt_q == '0) state_d = S_RUN;
            S_RUN:    if (cnt_q == '0) state_d = S_SAMPLE;
            S_SAMPLE: if (cnt_q == '0) state_d = S_REPORT;
            S_REPORT: if ((k_q == '0 && mismatch_q) || k_q == K_LAST) begin
                          state_d = S_DONE;
                      end else begin
                          state_d = S_ARST;
                          k_d     = k_q + KW'(1);
                      end
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
        if (abort && state_q != S_IDLE && state_q != S_DONE) state_d = S_DONE;

        if (state_d != state_q) begin
            case (state_d)
                S_ARST:   cnt_d = CW'(1);
                S_RUN:    cnt_d = CW'(LAT - 1);
                S_SAMPLE: cnt_d = CW'(SAMPLES - 1);
                default:  cnt_d = '0;
            endcase
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
        end

        if (state_d == S_ARST && state_q != S_ARST) mismatch_d = 1'b0;
        else if (state_q == S_SAMPLE)               mismatch_d = mismatch_fin;

        // The verdict is latched on the edge that enters REPORT, so an abort there discards it.
        report_now  = (state_q == S_SAMPLE) && (state_d == S_REPORT);
        res_valid_d = report_now && (k_q != '0);
        res_pe_d    = res_valid_d ? km1[PW:1] : res_pe_q;
        res_stuck_d = res_valid_d ? km1[0] : res_stuck_q;
        res_det_d   = res_valid_d ? mismatch_fin : res_det_q;
        dmap_d      = dmap_q;
        sanity_d    = sanity_q;
        if (state_q == S_IDLE && start) begin
            dmap_d   = '0;
            sanity_d = 1'b0;
        end
        if (res_valid_d && mismatch_fin) dmap_d = dmap_q | (FW'(1) << km1);
        if (report_now && k_q == '0)     sanity_d = mismatch_fin;

        busy_d    = (state_d != S_IDLE);
        done_d    = (state_d == S_DONE);
        arr_rst_d = (state_d == S_ARST);
        fault_d   = '0;
        left_d    = '0;
        top_d     = '0;
        ctl_op2_d = 1'b0;
        ctl_out_d = 1'b0;
        case (state_d)
            S_ARST: fault_d = fault_pattern(k_d);
            S_RUN, S_SAMPLE, S_REPORT: begin
                fault_d   = fault_q;
                left_d    = (state_q == S_ARST) ? op_left : left_q;
                top_d     = (state_q == S_ARST) ? op_top : top_q;
                ctl_op2_d = 1'b1;
                ctl_out_d = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            k_q         <= '0;
            mismatch_q  <= 1'b0;
            arr_rst_q   <= 1'b0;
            ctl_op2_q   <= 1'b0;
            ctl_out_q   <= 1'b0;
            left_q      <= '0;
            top_q       <= '0;
            fault_q     <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            sanity_q    <= 1'b0;
            res_valid_q <= 1'b0;
            res_pe_q    <= '0;
            res_stuck_q <= 1'b0;
            res_det_q   <= 1'b0;
            dmap_q      <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            k_q         <= k_d;
            mismatch_q  <= mismatch_d;
            arr_rst_q   <= arr_rst_d;
            ctl_op2_q   <= ctl_op2_d;
            ctl_out_q   <= ctl_out_d;
            left_q      <= left_d;
            top_q       <= top_d;
            fault_q     <= fault_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            sanity_q    <= sanity_d;
            res_valid_q <= res_valid_d;
            res_pe_q    <= res_pe_d;
            res_stuck_q <= res_stuck_d;
            res_det_q   <= res_det_d;
            dmap_q      <= dmap_d;
        end
    end

    assign arr_rst                     = arr_rst_q;
    assign ctl_stat_bit_in             = 1'b0;
    assign ctl_dummy_fsm_op2_select_in = ctl_op2_q;
    assign ctl_dummy_fsm_out_select_in = ctl_out_q;
    assign left_in_bus                 = left_q;
    assign top_in_bus                  = top_q;
    assign fault_inject_bus            = fault_q;
    assign busy                        = busy_q;
    assign done                        = done_q;
    assign sanity_fail                 = sanity_q;
    assign res_valid                   = res_valid_q;
    assign res_pe                      = res_pe_q;
    assign res_stuck                   = res_stuck_q;
    assign res_detected                = res_det_q;
    assign detect_map                  = dmap_q;
    assign dbg_state                   = state_q;
endmodule

// File: tb/tb_fi_campaign_ctrl.sv
// Directed bench for fi_campaign_ctrl on the default 2x2, 16-bit configuration with a stub DUT/golden pair.
module tb_fi_campaign_ctrl;
    localparam logic [31:0] GOLD    = 32'h1234_0abc;
    localparam logic [31:0] OP_LEFT = {16'd5, 16'd4};
    localparam logic [31:0] OP_TOP  = {16'd3, 16'd2};

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [31:0] op_left = '0;
    logic [31:0] op_top = '0;
    logic        arr_rst, ctl_stat, ctl_op2, ctl_out;
    logic [31:0] left_in_bus, top_in_bus;
    logic [7:0]  fault_inject_bus;
    logic [31:0] dut_bus, gold_bus;
    logic        busy, done, sanity_fail, res_valid, res_stuck, res_detected;
    logic [1:0]  res_pe;
    logic [7:0]  detect_map;
    logic [2:0]  dbg_state;

    int          stub_mode = 2;
    logic [31:0] rand_dut = '0, rand_gold = '0;

    int          n_tests = 0, n_fail = 0;
    logic [3:0]  exp_q[$];
    logic [3:0]  got_q[$];
    int          got_rel_q[$];
    int          done_rel;

    fi_campaign_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .op_left(op_left), .op_top(op_top),
        .arr_rst(arr_rst), .ctl_stat_bit_in(ctl_stat),
        .ctl_dummy_fsm_op2_select_in(ctl_op2), .ctl_dummy_fsm_out_select_in(ctl_out),
        .left_in_bus(left_in_bus), .top_in_bus(top_in_bus),
        .fault_inject_bus(fault_inject_bus),
        .dut_bottom_out_bus(dut_bus), .gold_bottom_out_bus(gold_bus),
        .busy(busy), .done(done), .sanity_fail(sanity_fail),
        .res_valid(res_valid), .res_pe(res_pe), .res_stuck(res_stuck),
        .res_detected(res_detected), .detect_map(detect_map), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    // Stub array: a fault is visible unless it is PE 2 stuck-at-0 (bus pattern 8'b0001_0000).
    always_comb begin
        gold_bus = GOLD;
        dut_bus  = GOLD;
        if (stub_mode == 2) begin
            gold_bus = rand_gold;
            dut_bus  = rand_dut;
        end else if (stub_mode == 1 || (fault_inject_bus != 8'h00 && fault_inject_bus != 8'b0001_0000)) begin
            dut_bus = GOLD ^ 32'd1;
        end
    end

    function automatic logic [127:0] all_outs();
        return {arr_rst, ctl_stat, ctl_op2, ctl_out, left_in_bus, top_in_bus, fault_inject_bus,
                busy, done, sanity_fail, res_valid, res_pe, res_stuck, res_detected, detect_map};
    endfunction

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Pulses start so that the first negedge after edge E is relative cycle 1, then observes.
    task automatic run_campaign(input int max_c, input int abort_c, input int rst_c,
                                input int extra_start_c, input bit chk_inj);
        got_q.delete();
        got_rel_q.delete();
        done_rel = -1;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        for (int c = 1; c <= max_c; c++) begin
            if (c > 1) @(negedge clk);
            start = (c == extra_start_c);
            abort = (c == abort_c);
            if (c == rst_c) begin
                rst = 1'b0;
                #1;
                check("rst_async_outs", all_outs(), '0);
                check("rst_async_state", dbg_state, 3'd0);
                return;
            end
            if (chk_inj && c == 1) begin
                check("arst_left_zero", left_in_bus, 32'd0);
                check("arst_busy", busy, 1'b1);
            end
            if (chk_inj && c == 3) begin
                check("run_left", left_in_bus, OP_LEFT);
                check("run_top", top_in_bus, OP_TOP);
                check("run_ctl", {ctl_stat, ctl_op2, ctl_out}, 3'b011);
                check("run_arst_low", arr_rst, 1'b0);
            end
            if (chk_inj && c >= 67 && c <= 77) begin
                check("inj_bus_k6", fault_inject_bus, 8'b0011_0000);
                check("inj_arst_k6", arr_rst, (c <= 68));
            end
            if (res_valid) begin
                got_q.push_back({res_pe, res_stuck, res_detected});
                got_rel_q.push_back(c);
            end
            if (done) begin
                done_rel = c;
                break;
            end
        end
        start = 1'b0;
        abort = 1'b0;
    endtask

    initial begin
        // Reset with random inputs: everything must stay at zero.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            start     = 1'($urandom_range(0, 1));
            abort     = 1'($urandom_range(0, 1));
            op_left   = $urandom();
            op_top    = $urandom();
            rand_dut  = $urandom();
            rand_gold = $urandom();
            #1;
            check("reset_outs", all_outs(), '0);
        end
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        stub_mode = 0;
        op_left = OP_LEFT;
        op_top = OP_TOP;
        rst = 1'b1;
        repeat (5) @(negedge clk);
        check("idle_after_reset", all_outs(), '0);

        // Full campaign, with an ignored start while busy.
        for (int k = 1; k <= 8; k++) begin
            logic [1:0] p;
            logic       s;
            p = 2'((k - 1) >> 1);
            s = 1'((k - 1) & 1);
            exp_q.push_back({p, s, !(p == 2'd2 && s == 1'b0)});
        end
        run_campaign(150, 0, 0, 30, 1'b1);
        check("full_done_cycle", done_rel, 100);
        check("full_res_count", got_q.size(), 8);
        for (int i = 0; i < got_q.size() && i < 8; i++) begin
            check("full_res_entry", got_q[i], exp_q[i]);
            check("full_res_cycle", got_rel_q[i], 11 + 11 * (i + 1));
        end
        check("full_detect_map", detect_map, 8'b1110_1111);
        check("full_sanity", sanity_fail, 1'b0);
        check("full_done_bus", {fault_inject_bus, left_in_bus, arr_rst}, '0);
        @(negedge clk);
        check("full_busy_fall", {busy, done}, 2'b00);

        // Sanity failure: stub mismatches during the fault-free run.
        stub_mode = 1;
        run_campaign(40, 0, 0, 0, 1'b0);
        stub_mode = 0;
        check("san_done_cycle", done_rel, 12);
        check("san_res_count", got_q.size(), 0);
        check("san_flag", sanity_fail, 1'b1);
        check("san_detect_map", detect_map, 8'h00);
        @(negedge clk);
        check("san_sticky_idle", {sanity_fail, busy}, 2'b10);

        // Abort in SAMPLE of run k=3 (cycles 40..43).
        run_campaign(60, 41, 0, 0, 1'b0);
        check("abort_done_cycle", done_rel, 42);
        check("abort_res_count", got_q.size(), 2);
        check("abort_fault_bus", fault_inject_bus, 8'h00);
        check("abort_left_bus", left_in_bus, 32'd0);
        check("abort_detect_map", detect_map, 8'b0000_0011);
        @(negedge clk);
        check("abort_idle", {busy, done}, 2'b00);

        // Asynchronous reset mid-campaign.
        run_campaign(60, 0, 50, 0, 1'b0);
        repeat (2) @(negedge clk);
        check("rst_hold_outs", all_outs(), '0);
        rst = 1'b1;
        repeat (4) @(negedge clk);
        check("rst_release_idle", all_outs(), '0);
        check("rst_release_state", dbg_state, 3'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
